// File: rtl/host_exit_monitor.sv
// Host exit monitor. It watches the dmem write channels for stores to tohost, latches the run verdict,
// exit code, cycle count and winning port, and keeps a ring buffer of recent host writes.
module host_exit_monitor #(
  parameter int              NUM_PORTS   = 2,
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] TOHOST_ADDR = '0,
  parameter int              IGNORE_LSB  = 3,
  parameter int              HIST_DEPTH  = 8,
  localparam int             STRB_W      = XLEN / 8,
  localparam int             PORT_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int             IDX_W       = $clog2(HIST_DEPTH),
  localparam int             CNT_W       = IDX_W + 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clear,
  input  logic [31:0]                 max_cycles,
  input  logic [NUM_PORTS-1:0]        mem_valid,
  input  logic [NUM_PORTS*XLEN-1:0]   mem_addr,
  input  logic [NUM_PORTS*STRB_W-1:0] mem_wstrb,
  input  logic [NUM_PORTS*XLEN-1:0]   mem_wdata,
  output logic                        done,
  output logic                        pass,
  output logic                        fail,
  output logic                        timeout,
  output logic [XLEN-1:0]             exit_code,
  output logic [PORT_W-1:0]           hit_port,
  output logic [31:0]                 cycle_count,
  output logic [CNT_W-1:0]            hist_count,
  output logic                        hist_drop,
  input  logic [IDX_W-1:0]            hist_rd_idx,
  output logic [XLEN-1:0]             hist_rd_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic              done_q, pass_q, fail_q, timeout_q, hist_drop_q;
  logic [XLEN-1:0]   exit_code_q;
  logic [PORT_W-1:0] hit_port_q;
  logic [31:0]       cycle_count_q;
  logic [CNT_W-1:0]  hist_count_q;
  logic [IDX_W-1:0]  wr_ptr_q;
  logic [XLEN-1:0]   hist_q [HIST_DEPTH];

  logic [NUM_PORTS-1:0] hit;
  logic                 any_hit;
  logic                 multi_hit;
  logic [PORT_W-1:0]    win_port;
  logic [XLEN-1:0]      win_data;
  logic                 timeout_now;
  logic [IDX_W-1:0]     rd_ptr;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    hit       = '0;
    any_hit   = 1'b0;
    multi_hit = 1'b0;
    win_port  = '0;
    win_data  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      hit[i] = mem_valid[i]
            && (|mem_wstrb[i*STRB_W +: STRB_W])
            && (mem_addr[i*XLEN+IGNORE_LSB +: XLEN-IGNORE_LSB] == TOHOST_ADDR[XLEN-1:IGNORE_LSB]);
    end
    // Scan from the top down so that the lowest hitting port is the last one assigned.
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_port = PORT_W'(i);
        win_data = mem_wdata[i*XLEN +: XLEN];
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (hit[i]) begin
        if (any_hit) multi_hit = 1'b1;
        any_hit = 1'b1;
      end
    end
  end

  assign timeout_now = (max_cycles != 32'd0) && (cycle_count_q == max_cycles - 32'd1);

  // NOTE: sequential state uses non-blocking assignments. The history memory is reset
  // as well, because a post-mortem read must never return stale data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      timeout_q     <= 1'b0;
      hist_drop_q   <= 1'b0;
      exit_code_q   <= '0;
      hit_port_q    <= '0;
      cycle_count_q <= '0;
      hist_count_q  <= '0;
      wr_ptr_q      <= '0;
      for (int k = 0; k < HIST_DEPTH; k++) hist_q[k] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cycle_count_q <= '0;
          if (!clear) state_q <= S_RUN;
        end
        S_RUN: begin
          if (clear) begin
            state_q       <= S_IDLE;
            cycle_count_q <= '0;
          end else begin
            cycle_count_q <= cycle_count_q + 32'd1;
            if (any_hit) begin
              hist_q[wr_ptr_q] <= win_data;
              wr_ptr_q         <= wr_ptr_q + IDX_W'(1);
              if (hist_count_q != CNT_W'(HIST_DEPTH)) hist_count_q <= hist_count_q + CNT_W'(1);
              if (multi_hit) hist_drop_q <= 1'b1;
            end
            // A terminating hit beats a timeout that falls on the same edge.
            if (any_hit && (win_data != '0)) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              pass_q      <= (win_data == XLEN'(1));
              fail_q      <= (win_data != XLEN'(1));
              exit_code_q <= win_data;
              hit_port_q  <= win_port;
            end else if (timeout_now) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              timeout_q   <= 1'b1;
              exit_code_q <= '0;
              hit_port_q  <= '0;
            end
          end
        end
        S_DONE: ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_ptr       = wr_ptr_q - IDX_W'(1) - hist_rd_idx;
  assign hist_rd_data = ({1'b0, hist_rd_idx} < hist_count_q) ? hist_q[rd_ptr] : '0;

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign exit_code   = exit_code_q;
  assign hit_port    = hit_port_q;
  assign cycle_count = cycle_count_q;
  assign hist_count  = hist_count_q;
  assign hist_drop   = hist_drop_q;

endmodule

// File: tb/tb_host_exit_monitor.sv
// Self-checking bench for host_exit_monitor. A queue-based model of the exit rules is compared
// every cycle, and hand-computed literal expectations pin the model at each scenario.
module tb_host_exit_monitor;

  localparam int          NP     = 2;
  localparam int          XL     = 32;
  localparam int          IL     = 3;
  localparam int          HD     = 8;
  localparam logic [31:0] TOHOST = 32'h8000_1000;

  logic          clock = 1'b0;
  logic          reset;
  logic          clear;
  logic [31:0]   max_cycles;
  logic [NP-1:0] mem_valid;
  logic [63:0]   mem_addr;
  logic [7:0]    mem_wstrb;
  logic [63:0]   mem_wdata;
  logic          done, pass, fail, timeout, hist_drop;
  logic [31:0]   exit_code, cycle_count, hist_rd_data;
  logic [0:0]    hit_port;
  logic [3:0]    hist_count;
  logic [2:0]    hist_rd_idx;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  host_exit_monitor #(
    .NUM_PORTS(NP), .XLEN(XL), .TOHOST_ADDR(TOHOST), .IGNORE_LSB(IL), .HIST_DEPTH(HD)
  ) dut (
    .clock(clock), .reset(reset), .clear(clear), .max_cycles(max_cycles),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout), .exit_code(exit_code),
    .hit_port(hit_port), .cycle_count(cycle_count), .hist_count(hist_count),
    .hist_drop(hist_drop), .hist_rd_idx(hist_rd_idx), .hist_rd_data(hist_rd_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase, sticky verdict and history as a most-recent-first queue.
  typedef enum {PH_IDLE, PH_RUN, PH_DONE} phase_e;
  phase_e      ph;
  logic [31:0] m_cc, m_exit;
  bit          m_done, m_pass, m_fail, m_to, m_drop;
  int          m_port;
  logic [31:0] m_hist[$];

  task automatic model_reset();
    ph = PH_IDLE; m_cc = 0; m_exit = 0; m_port = 0;
    m_done = 0; m_pass = 0; m_fail = 0; m_to = 0; m_drop = 0;
    m_hist.delete();
  endtask

  task automatic model_step();
    int          winners[$];
    logic [31:0] d;
    case (ph)
      PH_IDLE: if (!clear) ph = PH_RUN;
      PH_RUN: begin
        if (clear) begin
          ph = PH_IDLE; m_cc = 0;
        end else begin
          for (int p = 0; p < NP; p++)
            if (mem_valid[p] && mem_wstrb[p*4 +: 4] != 4'h0
                && (mem_addr[p*32 +: 32] >> IL) == (TOHOST >> IL))
              winners.push_back(p);
          m_cc = m_cc + 1;
          if (winners.size() > 0) begin
            d = mem_wdata[winners[0]*32 +: 32];
            m_hist.push_front(d);
            if (m_hist.size() > HD) void'(m_hist.pop_back());
            if (winners.size() > 1) m_drop = 1;
            if (d != 0) begin
              ph = PH_DONE; m_done = 1; m_pass = (d == 1); m_fail = (d != 1);
              m_exit = d; m_port = winners[0];
            end
          end
          if (ph == PH_RUN && max_cycles != 0 && m_cc == max_cycles) begin
            ph = PH_DONE; m_done = 1; m_to = 1; m_exit = 0;
          end
        end
      end
      default: ;
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  task automatic compare_all();
    logic [31:0] exp_rd;
    exp_rd = (int'(hist_rd_idx) < m_hist.size()) ? m_hist[hist_rd_idx] : 32'd0;
    check("done",         done,         m_done);
    check("pass",         pass,         m_pass);
    check("fail",         fail,         m_fail);
    check("timeout",      timeout,      m_to);
    check("exit_code",    exit_code,    m_exit);
    check("hit_port",     hit_port,     m_port);
    check("cycle_count",  cycle_count,  m_cc);
    check("hist_count",   hist_count,   m_hist.size());
    check("hist_drop",    hist_drop,    m_drop);
    check("hist_rd_data", hist_rd_data, exp_rd);
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (cmp_en) compare_all();
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic idle_inputs();
    mem_valid = '0; mem_addr = '0; mem_wstrb = '0; mem_wdata = '0;
  endtask

  task automatic set_port(input int p, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    mem_valid[p]          = 1'b1;
    mem_addr[p*32 +: 32]  = addr;
    mem_wdata[p*32 +: 32] = data;
    mem_wstrb[p*4 +: 4]   = strb;
  endtask

  task automatic do_reset(input logic [31:0] maxc);
    reset = 1'b0; idle_inputs(); clear = 1'b0; hist_rd_idx = '0;
    tick(2);
    max_cycles = maxc;
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; max_cycles = 0; hist_rd_idx = '0; idle_inputs();
    tick(2);
    cmp_en = 1'b1;
    check("rst done", done, 0);
    check("rst cycle_count", cycle_count, 0);
    check("rst hist_count", hist_count, 0);

    // 1: port0 writes 1; the hit is sampled while the count is 19, so the count ends at 20.
    reset = 1'b1; tick(20);
    set_port(0, TOHOST, 32'd1, 4'hF); tick(1); idle_inputs();
    check("t1 done", done, 1);
    check("t1 pass", pass, 1);
    check("t1 fail", fail, 0);
    check("t1 exit_code", exit_code, 1);
    check("t1 hit_port", hit_port, 0);
    check("t1 cycle_count", cycle_count, 20);
    check("t1 hist_rd0", hist_rd_data, 1);

    // 2: port1 writes 0x55 to an address inside the ignored low bits.
    do_reset(0); reset = 1'b1; tick(6);
    set_port(1, TOHOST + 32'd4, 32'h55, 4'h1); tick(1); idle_inputs();
    check("t2 fail", fail, 1);
    check("t2 pass", pass, 0);
    check("t2 exit_code", exit_code, 32'h55);
    check("t2 hit_port", hit_port, 1);
    check("t2 cycle_count", cycle_count, 6);

    // 3: both ports hit together; the lower port wins and the other write is dropped.
    do_reset(0); reset = 1'b1; tick(4);
    set_port(0, TOHOST, 32'd7, 4'h3); set_port(1, TOHOST, 32'd1, 4'hF); tick(1); idle_inputs();
    check("t3 hit_port", hit_port, 0);
    check("t3 exit_code", exit_code, 7);
    check("t3 fail", fail, 1);
    check("t3 hist_drop", hist_drop, 1);
    check("t3 hist_count", hist_count, 1);
    check("t3 hist_rd0", hist_rd_data, 7);
    hist_rd_idx = 3'd1; #1;
    check("t3 hist_rd1 beyond count", hist_rd_data, 0);

    // 4a: timeout at 100 cycles with no hits.
    do_reset(100); reset = 1'b1; tick(120);
    check("t4a timeout", timeout, 1);
    check("t4a done", done, 1);
    check("t4a exit_code", exit_code, 0);
    check("t4a cycle_count", cycle_count, 100);
    check("t4a pass", pass, 0);

    // 4b: a hit at count 99 coincides with the timeout edge, and the hit wins.
    do_reset(100); reset = 1'b1; tick(100);
    set_port(0, TOHOST, 32'd1, 4'hF); tick(1); idle_inputs();
    check("t4b pass", pass, 1);
    check("t4b timeout", timeout, 0);
    check("t4b cycle_count", cycle_count, 100);
    tick(5);
    check("t4b cycle_count frozen", cycle_count, 100);

    // 5: ten zero-data writes, then two non-hits (zero strobe, address outside the window), then data 3.
    do_reset(0); reset = 1'b1; tick(2);
    for (int i = 0; i < 10; i++) begin
      set_port(0, TOHOST, 32'd0, 4'(i + 1)); tick(1);
    end
    check("t5 hist_count sat", hist_count, 8);
    check("t5 not done", done, 0);
    set_port(0, TOHOST, 32'd0, 4'h0); tick(1);
    set_port(0, TOHOST + 32'd8, 32'd0, 4'hF); tick(1);
    set_port(0, TOHOST, 32'd3, 4'hF); tick(1); idle_inputs();
    check("t5 fail", fail, 1);
    check("t5 exit_code", exit_code, 3);
    check("t5 cycle_count", cycle_count, 14);
    check("t5 hist_count", hist_count, 8);
    for (int i = 0; i < HD; i++) begin
      hist_rd_idx = 3'(i); #1;
      check($sformatf("t5 hist_rd%0d", i), hist_rd_data, (i == 0) ? 32'd3 : 32'd0);
    end
    hist_rd_idx = '0;
    set_port(1, TOHOST, 32'd1, 4'hF); tick(3); idle_inputs();
    check("t5 post-done exit_code", exit_code, 3);
    check("t5 post-done pass", pass, 0);
    check("t5 post-done hit_port", hit_port, 0);
    check("t5 post-done cycle_count", cycle_count, 14);
    check("t5 post-done hist_rd0", hist_rd_data, 3);

    // 6: asynchronous reset at count 50, then clear held for 5 cycles, then restart.
    do_reset(0); reset = 1'b1; tick(51);
    check("t6 running", cycle_count, 50);
    reset = 1'b0; #1;
    check("t6 async cycle_count", cycle_count, 0);
    check("t6 async done", done, 0);
    tick(2);
    clear = 1'b1; reset = 1'b1;
    tick(2); set_port(0, TOHOST, 32'd1, 4'hF); tick(1); idle_inputs(); tick(2);
    check("t6 clear cycle_count", cycle_count, 0);
    check("t6 clear ignores hit", done, 0);
    check("t6 clear hist_count", hist_count, 0);
    clear = 1'b0; tick(1);
    check("t6 restart cc0", cycle_count, 0);
    tick(1);
    check("t6 restart cc1", cycle_count, 1);
    set_port(1, TOHOST, 32'd0, 4'h8); tick(1); idle_inputs();
    check("t6 zero hit pushed", hist_count, 1);
    clear = 1'b1; tick(1); clear = 1'b0;
    check("t6 clear in RUN cc", cycle_count, 0);
    check("t6 clear keeps history", hist_count, 1);
    tick(3);
    set_port(0, TOHOST, 32'd2, 4'hF); tick(1); idle_inputs();
    check("t6 final exit_code", exit_code, 2);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
